line_drawer_stream: RTL
=======================

# line_drawer_stream

Parametrised successor to the single-line Bresenham drawer. It accepts line or clear commands over a valid/ready handshake and draws lines in all eight octants. Pixels are emitted as a backpressured stream with a per-command colour, and off-screen pixels are clipped. It sits between the command source (test pattern or CPU) and the framebuffer write port.

## Interface
Parameters:
- COORD_W, 11, width of every coordinate.
- SCREEN_W, 640, visible width; pixels with x ≥ SCREEN_W are clipped.
- SCREEN_H, 480, visible height; pixels with y ≥ SCREEN_H are clipped.
- COLOR_W, 1, colour width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_mode  in  1  0 = LINE, 1 = CLEAR (fill whole screen).
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  COORD_W each  line end points, unsigned; ignored in CLEAR.
- cmd_color  in  COLOR_W  colour for every pixel of the command.
- pix_valid  out  1  pixel present.
- pix_ready  in  1  sink accepts pixel.
- pix_x, pix_y  out  COORD_W each  pixel coordinate.
- pix_color  out  COLOR_W  pixel colour.
- done  out  1  one-cycle pulse: command finished.

## Operation
- States: IDLE, SETUP, LINE, CLEAR. cmd_ready = (state == IDLE). A command is captured on cmd_valid && cmd_ready. The capture registers the end points, mode and colour.
- SETUP (one cycle) performs octant normalisation:
  - steep = |y1−y0| > |x1−x0|.
  - If steep, swap x↔y in both points.
  - If x0 > x1, swap the points.
  - dx = x1−x0, dy = |y1−y0|, ystep = +1 if y0 < y1, else −1.
  - err = dx >> 1.
  - The cycle then goes to LINE, or to CLEAR for mode 1 with the counters at (0,0).
- LINE step:
  - Candidate pixel = (y,x) if steep, else (x,y).
  - On a handshake, or when the candidate is clipped: if x == x1, finish. Otherwise x += 1 and err −= dy; if err < 0 (after subtraction), y += ystep and err += dx.
- Arithmetic: err and dx/dy are signed COORD_W+2 bits. There is no overflow for any unsigned COORD_W inputs.
- Pixel count is max(|Δx|,|Δy|)+1 before clipping. Pixels are emitted from the lower major-axis end. x0==x1 && y0==y1 emits exactly one pixel.
- Clipping: a clipped candidate drives pix_valid low and advances one step per cycle without waiting for pix_ready. A fully off-screen line emits nothing and still pulses done.
- CLEAR: raster scan, y outer 0..SCREEN_H−1, x inner 0..SCREEN_W−1, all pixels with cmd_color. Each step advances on handshake; the last pixel is (SCREEN_W−1, SCREEN_H−1).
- Finish: state → IDLE and done pulses for one cycle.

## Timing
- Reset (reset_n low, async): state IDLE; cmd_ready=1 after release; pix_valid=0, pix_x=0, pix_y=0, pix_color=0, done=0; all internal counters and err cleared.
- Reset mid-command aborts immediately. No further pixels are emitted and done does not pulse.
- Latency: command accepted at edge T → SETUP in cycle T+1 → first pix_valid in cycle T+2.
- Throughput: one pixel per cycle while pix_ready=1.
- pix_valid, pix_x, pix_y and pix_color are registered. They are held stable while pix_valid && !pix_ready. pix_valid never drops without a handshake, except on reset.
- done is asserted in the cycle after the last step and coincides with cmd_ready returning to 1. A new command may be accepted in that same cycle.
- cmd_valid while busy is ignored (not captured). The source must hold it until cmd_ready.

## Structure
- Package line_pkg:
  - state enum (IDLE, SETUP, LINE, CLEAR).
  - mode constants MODE_LINE=0, MODE_CLEAR=1.
  - function err_width(COORD_W) = COORD_W+2.
- Sub-module line_octant_setup: combinational normalisation. Inputs are the captured end points; outputs are steep, normalised x0/x1/y0, dx, dy, ystep and initial err. It is registered by the parent in SETUP.
- Top: FSM, step datapath, clip compare, output register stage.

## Test plan
- LINE (0,0)→(100,20), pix_ready=1 → 101 pixels, first (0,0), last (100,20), y steps exactly 20 times, first pix_valid 2 cycles after accept, done once.
- LINE (10,50)→(3,0), steep, reversed → 51 pixels from (3,0) to (10,50), y strictly increasing by 1, x non-decreasing.
- LINE (5,5)→(5,5) → exactly one pixel (5,5), then done.
- LINE (630,10)→(650,10) with SCREEN_W=640 → 10 pixels x=630..639. A fully off-screen (700,0)→(710,0) emits 0 pixels and still gives done.
- LINE (0,0)→(7,7) with pix_ready toggled randomly → outputs stable during stalls; sequence (i,i) for i=0..7, no drops or duplicates.
- CLEAR colour 1 with SCREEN_W=4, SCREEN_H=3 → 12 pixels in raster order ending at (3,2); reset_n pulsed mid-CLEAR → pix_valid=0 immediately, done not pulsed, cmd_ready=1 after release.

Source files
------------

// File: rtl/line_pkg.sv
// Shared types and helpers for the streaming line drawer.
package line_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    LINE  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic MODE_LINE  = 1'b0;
  localparam logic MODE_CLEAR = 1'b1;

  // Error term and deltas need two extra bits: one for sign, one for the
  // transient err - dy swing below zero.
  function automatic int err_width(input int coord_w);
    return coord_w + 2;
  endfunction

endpackage

// File: rtl/line_octant_setup.sv
// Octant normalisation for Bresenham: folds any line into a left-to-right,
// shallow-slope walk and reports how to unfold each pixel.
module line_octant_setup
  import line_pkg::*;
#(
  parameter int COORD_W = 11,
  localparam int EW = err_width(COORD_W)
) (
  input  logic [COORD_W-1:0]    i_x0,
  input  logic [COORD_W-1:0]    i_y0,
  input  logic [COORD_W-1:0]    i_x1,
  input  logic [COORD_W-1:0]    i_y1,
  output logic                  o_steep,
  output logic [COORD_W-1:0]    o_x0,
  output logic [COORD_W-1:0]    o_x1,
  output logic [COORD_W-1:0]    o_y0,
  output logic signed [EW-1:0]  o_dx,
  output logic signed [EW-1:0]  o_dy,
  output logic                  o_ystep_pos,
  output logic signed [EW-1:0]  o_err
);

  logic [COORD_W-1:0] w_adx;
  logic [COORD_W-1:0] w_ady;
  logic [COORD_W-1:0] w_ax0;
  logic [COORD_W-1:0] w_ay0;
  logic [COORD_W-1:0] w_ax1;
  logic [COORD_W-1:0] w_ay1;
  logic [COORD_W-1:0] w_y1;

  // Steepness test, axis swap, endpoint ordering, then deltas and initial error.
  always_comb begin
    w_adx   = (i_x1 >= i_x0) ? (i_x1 - i_x0) : (i_x0 - i_x1);
    w_ady   = (i_y1 >= i_y0) ? (i_y1 - i_y0) : (i_y0 - i_y1);
    o_steep = (w_ady > w_adx);

    w_ax0 = o_steep ? i_y0 : i_x0;
    w_ay0 = o_steep ? i_x0 : i_y0;
    w_ax1 = o_steep ? i_y1 : i_x1;
    w_ay1 = o_steep ? i_x1 : i_y1;

    if (w_ax0 > w_ax1) begin
      o_x0 = w_ax1;
      o_x1 = w_ax0;
      o_y0 = w_ay1;
      w_y1 = w_ay0;
    end else begin
      o_x0 = w_ax0;
      o_x1 = w_ax1;
      o_y0 = w_ay0;
      w_y1 = w_ay1;
    end

    o_dx        = $signed({2'b00, o_x1 - o_x0});
    o_dy        = $signed({2'b00, (o_y0 < w_y1) ? (w_y1 - o_y0) : (o_y0 - w_y1)});
    o_ystep_pos = (o_y0 < w_y1);
    o_err       = o_dx >>> 1;
  end

endmodule

// File: rtl/line_drawer_stream.sv
// Streaming Bresenham line / screen-clear engine with clipping and a
// backpressured, registered pixel output.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// SETUP | one cycle: latch normalised octant values, present first pixel
// LINE  | walk the major axis; clipped pixels advance without handshake
// CLEAR | raster scan of the whole screen, one pixel per handshake
module line_drawer_stream
  import line_pkg::*;
#(
  parameter int COORD_W  = 11,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COLOR_W  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_mode,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               done
);

  localparam int EW = err_width(COORD_W);
  localparam logic [COORD_W:0]   LP_SW     = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0]   LP_SH     = (COORD_W+1)'(SCREEN_H);
  localparam logic [COORD_W-1:0] LP_X_LAST = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] LP_Y_LAST = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] LP_ONE    = COORD_W'(1);

  state_t              r_state;
  logic                r_mode;
  logic [COLOR_W-1:0]  r_color;
  logic [COORD_W-1:0]  r_x0, r_y0, r_x1, r_y1;
  logic                r_steep;
  logic                r_ystep_pos;
  logic [COORD_W-1:0]  r_x, r_y, r_x_end;
  logic signed [EW-1:0] r_dx, r_dy, r_err;
  logic                r_pix_valid;
  logic [COORD_W-1:0]  r_pix_x, r_pix_y;
  logic [COLOR_W-1:0]  r_pix_color;
  logic                r_done;

  logic                w_s_steep;
  logic [COORD_W-1:0]  w_s_x0, w_s_x1, w_s_y0;
  logic signed [EW-1:0] w_s_dx, w_s_dy, w_s_err;
  logic                w_s_ystep_pos;
  logic [COORD_W-1:0]  w_s_px, w_s_py;

  logic signed [EW-1:0] w_err_sub, w_nerr;
  logic                w_y_step;
  logic [COORD_W-1:0]  w_nx, w_ny, w_ln_px, w_ln_py;
  logic                w_line_adv, w_pix_hs;
  logic [COORD_W-1:0]  w_cl_nx, w_cl_ny;
  logic                w_cl_row_end, w_cl_last;

  function automatic logic f_clipped(input logic [COORD_W-1:0] px,
                                     input logic [COORD_W-1:0] py);
    return ({1'b0, px} >= LP_SW) || ({1'b0, py} >= LP_SH);
  endfunction

  line_octant_setup #(.COORD_W(COORD_W)) u_setup (
    .i_x0        (r_x0),
    .i_y0        (r_y0),
    .i_x1        (r_x1),
    .i_y1        (r_y1),
    .o_steep     (w_s_steep),
    .o_x0        (w_s_x0),
    .o_x1        (w_s_x1),
    .o_y0        (w_s_y0),
    .o_dx        (w_s_dx),
    .o_dy        (w_s_dy),
    .o_ystep_pos (w_s_ystep_pos),
    .o_err       (w_s_err)
  );

  // Next Bresenham step, screen mapping of candidates, and raster-scan successor.
  always_comb begin
    w_err_sub = r_err - r_dy;
    w_y_step  = w_err_sub[EW-1];
    w_nx      = r_x + LP_ONE;
    w_ny      = w_y_step ? (r_ystep_pos ? (r_y + LP_ONE) : (r_y - LP_ONE)) : r_y;
    w_nerr    = w_y_step ? (w_err_sub + r_dx) : w_err_sub;
    w_ln_px   = r_steep ? w_ny : w_nx;
    w_ln_py   = r_steep ? w_nx : w_ny;

    w_s_px    = w_s_steep ? w_s_y0 : w_s_x0;
    w_s_py    = w_s_steep ? w_s_x0 : w_s_y0;

    // A low pix_valid inside LINE means the current candidate is clipped.
    w_line_adv = !r_pix_valid || pix_ready;
    w_pix_hs   = r_pix_valid && pix_ready;

    w_cl_row_end = (r_x == LP_X_LAST);
    w_cl_last    = w_cl_row_end && (r_y == LP_Y_LAST);
    w_cl_nx      = w_cl_row_end ? '0 : (r_x + LP_ONE);
    w_cl_ny      = w_cl_row_end ? (r_y + LP_ONE) : r_y;
  end

  // Control FSM with step datapath and registered pixel stage; the pixel
  // registers always hold the candidate the counters currently point at.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_mode      <= MODE_LINE;
      r_color     <= '0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_steep     <= 1'b0;
      r_ystep_pos <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_x_end     <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_color <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_mode  <= cmd_mode;
            r_color <= cmd_color;
            r_x0    <= cmd_x0;
            r_y0    <= cmd_y0;
            r_x1    <= cmd_x1;
            r_y1    <= cmd_y1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_pix_color <= r_color;
          if (r_mode == MODE_CLEAR) begin
            r_x         <= '0;
            r_y         <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_valid <= 1'b1;
            r_state     <= CLEAR;
          end else begin
            r_steep     <= w_s_steep;
            r_ystep_pos <= w_s_ystep_pos;
            r_x         <= w_s_x0;
            r_y         <= w_s_y0;
            r_x_end     <= w_s_x1;
            r_dx        <= w_s_dx;
            r_dy        <= w_s_dy;
            r_err       <= w_s_err;
            r_pix_x     <= w_s_px;
            r_pix_y     <= w_s_py;
            r_pix_valid <= !f_clipped(w_s_px, w_s_py);
            r_state     <= LINE;
          end
        end
        LINE: begin
          if (w_line_adv) begin
            if (r_x == r_x_end) begin
              r_pix_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_x         <= w_nx;
              r_y         <= w_ny;
              r_err       <= w_nerr;
              r_pix_x     <= w_ln_px;
              r_pix_y     <= w_ln_py;
              r_pix_valid <= !f_clipped(w_ln_px, w_ln_py);
            end
          end
        end
        CLEAR: begin
          if (w_pix_hs) begin
            if (w_cl_last) begin
              r_pix_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_x     <= w_cl_nx;
              r_y     <= w_cl_ny;
              r_pix_x <= w_cl_nx;
              r_pix_y <= w_cl_ny;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign pix_valid = r_pix_valid;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_color = r_pix_color;
  assign done      = r_done;

endmodule
